uart_tx_fifo_param: RTL and testbench
=====================================

Name: uart_tx_fifo_param

Overview:
Parametrised UART transmitter with a built-in input FIFO. Serialises words of DATA_BITS bits onto a single idle-high line in the frame order start bit, data LSB first, optional parity bit, then 1 or 2 stop bits. It replaces the fixed 8N1 single-word transmitter in the speech-processing datapath. Upstream logic writes words through a valid/ready handshake, and queued words are sent back-to-back with no idle gap between frames.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per bit period; must be >= 4. 5208 gives 9600 baud at 50 MHz.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.
FIFO_DEPTH, 4, input FIFO entries; power of 2, >= 2.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  upstream word valid.
in_ready  out  1  FIFO can accept a word.
in_data  in  DATA_BITS  word to transmit.
tx  out  1  serial line; idles high.
busy  out  1  high while a frame is on the line or the FIFO is non-empty.
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, while rst_n=0): tx=1, busy=0, in_ready=0, fifo_count=0. FIFO pointers, bit counter and prescaler cleared; serializer in IDLE.
- in_ready is 1 in the first cycle after reset release.
- Reset asserted mid-frame: tx returns to 1 immediately; the frame and all queued words are discarded.
- Handshake:
  - A word is pushed at the rising edge where in_valid && in_ready.
  - in_ready = (fifo_count < FIFO_DEPTH). It is registered/derived from count only and never depends on in_valid.
  - in_valid while in_ready=0 is ignored; the word is lost unless upstream holds it.
  - in_data is sampled only at the push edge.
- FIFO:
  - Synchronous write and read; overflow and underflow are impossible by construction.
  - A push and a pop in the same cycle leave the count unchanged.
- Serializer FSM, states IDLE, START, DATA, PARITY, STOP:
  - IDLE: tx=1. If the FIFO is non-empty: pop, load the shift register, compute parity over the popped word, go to START.
  - Each bit state holds tx for exactly CLKS_PER_BIT cycles. The prescaler counts 0..CLKS_PER_BIT-1, and the state or bit advances when prescaler == CLKS_PER_BIT-1.
  - START: tx=0.
  - DATA: tx = shift[0]; shift right after each bit. Exit after DATA_BITS bits.
  - PARITY: entered only if PARITY!=0. tx = XOR of the data bits for even mode, inverted XOR for odd mode.
  - STOP: tx=1 for STOP_BITS bit periods. On the last cycle of the final stop bit:
    - FIFO non-empty: pop and go directly to START; the next start bit begins the following cycle.
    - FIFO empty: go to IDLE.
- Latency: a push at edge N into an idle, empty block makes tx fall at edge N+2 (pop at N+1, start bit driven from N+2).
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- busy = (state != IDLE) || (fifo_count != 0); registered-equivalent, glitch-free.
- tx is driven from a flop.
- Out-of-range parameters are rejected by an elaboration-time check.

Decomposition:
- Package uart_pkg holds:
  - Parity mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - The serializer state enum.
  - A frame-bit-count helper function.
- Sub-module sync_fifo, with parameters WIDTH and DEPTH and ports clk, rst_n, wr_en, wr_data, rd_en, rd_data, count, full, empty.
- The serializer FSM stays in the top module.

Test Plan:
All tests use CLKS_PER_BIT=16.
1. 8N1, push 0xA5 while idle -> tx falls 2 edges after the push, then the line reads 0,1,0,1,0,0,1,0,1,1 with each level held 16 cycles; frame is 160 cycles; busy falls after the stop bit.
2. PARITY=2 (even), push 0xA5 -> parity bit 0. Repeat with PARITY=1 (odd) -> parity bit 1. Frame is 176 cycles.
3. DATA_BITS=7, STOP_BITS=2, push 0x41 -> data bits 1,0,0,0,0,0,1 followed by 32 cycles high; frame is 160 cycles.
4. FIFO_DEPTH=4, hold in_valid with 6 distinct words -> in_ready drops when fifo_count reaches 4 (the serializer has already popped word 1); all 6 words are transmitted in order; no idle cycle between the stop bit of frame k and the start bit of frame k+1.
5. Assert rst_n=0 mid-DATA with 3 words queued -> tx=1 and fifo_count=0 within the same cycle; after release there is no further transmission, and busy=0.
6. Present in_valid while in_ready=0 with word 0x3C -> 0x3C never appears on tx; fifo_count never exceeds 4.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity modes,
// serializer state encoding and frame sizing.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } ser_state_t;

    // Bit periods in one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_param_sync_fifo.sv
// Synchronous FIFO with show-ahead read data; writes when full and reads
// when empty are dropped, so the occupancy can never leave 0..DEPTH.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;
    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with input FIFO; queued words go out back-to-back.
// state    | meaning
// S_IDLE   | line high, waiting for a queued word
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit (only when parity is enabled)
// S_STOP   | stop bit(s), high; chains straight into the next START
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW         = $clog2(CLKS_PER_BIT);
    localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);

    generate
        if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
            (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) ||
            STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FRAME_BITS > 13) begin : g_bad_param
            $error("uart_tx_fifo_param: illegal parameter set");
        end
    endgenerate

    ser_state_t           r_state, w_state_nxt;
    logic [PW-1:0]        r_prescale, w_prescale_nxt;
    logic [3:0]           r_bit_cnt, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_parity, w_parity_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_busy;
    logic                 r_rdy_en;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_tick;
    logic                 w_par_load;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [DATA_BITS-1:0] w_fifo_data;

    // r_rdy_en keeps in_ready low while reset is held.
    assign in_ready   = r_rdy_en && !w_fifo_full;
    assign w_push     = in_valid && in_ready;
    assign w_tick     = (r_prescale == PW'(CLKS_PER_BIT - 1));
    assign w_par_load = (PARITY == PAR_ODD) ? ~(^w_fifo_data) : (^w_fifo_data);
    assign tx         = r_tx;
    assign busy       = r_busy;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_push),
        .wr_data (in_data),
        .rd_en   (w_pop),
        .rd_data (w_fifo_data),
        .count   (fifo_count),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_prescale_nxt = w_tick ? '0 : r_prescale + 1'b1;
        w_bit_nxt      = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_prescale_nxt = '0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_fifo_data;
                    w_parity_nxt = w_par_load;
                    w_state_nxt  = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                    w_bit_nxt   = '0;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_bit_cnt == 4'(STOP_BITS - 1)) begin
                        w_bit_nxt = '0;
                        if (!w_fifo_empty) begin
                            w_pop        = 1'b1;
                            w_shift_nxt  = w_fifo_data;
                            w_parity_nxt = w_par_load;
                            w_state_nxt  = S_START;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The line level is registered from the current state, so tx trails the state by one cycle.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (r_state)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_shift[0];
            S_PARITY: w_tx_nxt = r_parity;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_prescale <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_rdy_en   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prescale <= w_prescale_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (r_state != S_IDLE) || (fifo_count != '0);
            r_rdy_en   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Scoreboard bench: four transmitter configurations (8N1, 8E1, 8O1, 7N2) at 16 clocks per bit.
module tb_uart_tx_fifo_param;

    localparam int CPB     = 16;
    localparam int NDUT    = 4;
    localparam int DB[4]   = '{8, 8, 8, 7};
    localparam int PARM[4] = '{0, 2, 1, 0};
    localparam int SB[4]   = '{1, 1, 1, 2};

    typedef struct {
        int         idx;
        logic [8:0] data;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld    [NDUT];
    logic [8:0] dat    [NDUT];
    logic       rdy    [NDUT];
    logic       tx_w   [NDUT];
    logic       busy_w [NDUT];
    logic [2:0] cnt_w  [NDUT];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   frames [NDUT];
    int   last_start [NDUT];
    int   busy_fall [NDUT];
    int   st0[$];
    int   max_cnt0 = 0;
    exp_t expq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (int'(cnt_w[0]) > max_cnt0) max_cnt0 <= int'(cnt_w[0]);

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx_fifo_param #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DB[g]),
            .PARITY       (PARM[g]),
            .STOP_BITS    (SB[g]),
            .FIFO_DEPTH   (4)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (vld[g]),
            .in_ready   (rdy[g]),
            .in_data    (dat[g][DB[g]-1:0]),
            .tx         (tx_w[g]),
            .busy       (busy_w[g]),
            .fifo_count (cnt_w[g])
        );
    end

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n, inout bit ab);
        for (int i = 0; i < n && !ab; i++) begin
            @(posedge clk);
            #1;
            if (!rst_n) ab = 1'b1;
        end
    endtask

    // Frame receiver and scoreboard checker: one per transmitter.
    for (genvar g = 0; g < NDUT; g++) begin : g_mon
        initial begin
            int         s;
            int         j;
            bit         ab;
            logic [8:0] w;
            logic       pb;
            frames[g] = 0;
            forever begin
                @(posedge clk);
                #1;
                if (rst_n && tx_w[g] == 1'b0) begin
                    s  = cyc;
                    ab = 1'b0;
                    w  = '0;
                    pb = 1'b0;
                    last_start[g] = s;
                    if (g == 0) st0.push_back(s);
                    wait_cyc(CPB / 2, ab);
                    if (!ab) chk(tx_w[g] == 1'b0, $sformatf("start_bit_dut%0d", g), int'(tx_w[g]), 0);
                    for (int i = 0; i < DB[g]; i++) begin
                        wait_cyc(CPB, ab);
                        if (!ab) w[i] = tx_w[g];
                    end
                    if (PARM[g] != 0) begin
                        wait_cyc(CPB, ab);
                        pb = tx_w[g];
                    end
                    for (int i = 0; i < SB[g]; i++) begin
                        wait_cyc(CPB, ab);
                        if (!ab) chk(tx_w[g] == 1'b1, $sformatf("stop_bit%0d_dut%0d", i, g), int'(tx_w[g]), 1);
                    end
                    wait_cyc(CPB / 2 - 1, ab);
                    if (!ab) begin
                        j = -1;
                        for (int i = 0; i < expq.size(); i++) begin
                            if (j < 0 && expq[i].idx == g) j = i;
                        end
                        if (j < 0) begin
                            chk(1'b0, $sformatf("unexpected_frame_dut%0d", g), int'(w), -1);
                        end else begin
                            chk(w == expq[j].data, $sformatf("data_dut%0d", g), int'(w), int'(expq[j].data));
                            if (PARM[g] != 0)
                                chk(pb == expq[j].par, $sformatf("parity_dut%0d", g), int'(pb), int'(expq[j].par));
                            expq.delete(j);
                        end
                        frames[g]++;
                    end
                end
            end
        end

        initial begin
            logic prev;
            prev = 1'b0;
            busy_fall[g] = -1;
            forever begin
                @(posedge clk);
                #1;
                if (prev && !busy_w[g]) busy_fall[g] = cyc;
                prev = busy_w[g];
            end
        end
    end

    task automatic push(input int k, input logic [8:0] d, input logic par, output int pc);
        bit done;
        done = 1'b0;
        pc   = -1;
        @(negedge clk);
        vld[k] = 1'b1;
        dat[k] = d;
        for (int t = 0; t < 2000 && !done; t++) begin
            if (rdy[k]) begin
                @(posedge clk);
                #1;
                pc = cyc;
                expq.push_back('{idx: k, data: d, par: par});
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk(1'b0, $sformatf("push_timeout_dut%0d", k), 0, 1);
    endtask

    task automatic drop(input int k);
        @(negedge clk);
        vld[k] = 1'b0;
    endtask

    task automatic wait_frames(input int k, input int target, input int budget);
        int t;
        t = 0;
        while (frames[k] < target && t < budget) begin
            @(posedge clk);
            t++;
        end
        if (frames[k] < target) chk(1'b0, $sformatf("frame_timeout_dut%0d", k), frames[k], target);
    endtask

    initial begin
        int pc;
        int f0;
        for (int k = 0; k < NDUT; k++) begin
            vld[k] = 1'b0;
            dat[k] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk(tx_w[0] == 1'b1, "reset_tx", int'(tx_w[0]), 1);
        chk(busy_w[0] == 1'b0, "reset_busy", int'(busy_w[0]), 0);
        chk(rdy[0] == 1'b0, "reset_in_ready", int'(rdy[0]), 0);
        chk(cnt_w[0] == 3'd0, "reset_fifo_count", int'(cnt_w[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk(rdy[0] == 1'b1, "ready_after_reset", int'(rdy[0]), 1);
        chk(rdy[3] == 1'b1, "ready_after_reset_7n2", int'(rdy[3]), 1);

        // 1: 8N1 0xA5
        push(0, 9'h0A5, 1'b0, pc);
        drop(0);
        wait_frames(0, 1, 400);
        chk(last_start[0] - pc == 2, "latency_8n1", last_start[0] - pc, 2);
        repeat (4) @(posedge clk);
        chk(busy_fall[0] - last_start[0] == 160, "frame_len_8n1", busy_fall[0] - last_start[0], 160);

        // 2: even and odd parity on 0xA5
        push(1, 9'h0A5, 1'b0, pc);
        drop(1);
        push(2, 9'h0A5, 1'b1, pc);
        drop(2);
        wait_frames(1, 1, 400);
        wait_frames(2, 1, 400);
        repeat (4) @(posedge clk);
        chk(busy_fall[1] - last_start[1] == 176, "frame_len_8e1", busy_fall[1] - last_start[1], 176);
        chk(busy_fall[2] - last_start[2] == 176, "frame_len_8o1", busy_fall[2] - last_start[2], 176);

        // 3: 7 data bits, 2 stop bits, 0x41
        push(3, 9'h041, 1'b0, pc);
        drop(3);
        wait_frames(3, 1, 400);
        repeat (4) @(posedge clk);
        chk(busy_fall[3] - last_start[3] == 160, "frame_len_7n2", busy_fall[3] - last_start[3], 160);

        // 4: six words with valid held, back-to-back frames
        st0.delete();
        f0 = frames[0];
        push(0, 9'h011, 1'b0, pc);
        push(0, 9'h022, 1'b0, pc);
        push(0, 9'h033, 1'b0, pc);
        push(0, 9'h044, 1'b0, pc);
        push(0, 9'h055, 1'b0, pc);
        chk(cnt_w[0] == 3'd4, "full_count", int'(cnt_w[0]), 4);
        chk(rdy[0] == 1'b0, "full_in_ready", int'(rdy[0]), 0);
        push(0, 9'h066, 1'b0, pc);
        drop(0);
        wait_frames(0, f0 + 6, 1500);
        if (st0.size() == 6) begin
            for (int i = 0; i < 5; i++)
                chk(st0[i+1] - st0[i] == 160, $sformatf("b2b_gap%0d", i), st0[i+1] - st0[i], 160);
        end else begin
            chk(1'b0, "b2b_frame_count", st0.size(), 6);
        end

        // 6: word offered while full is ignored
        f0 = frames[0];
        push(0, 9'h081, 1'b0, pc);
        push(0, 9'h092, 1'b0, pc);
        push(0, 9'h0A3, 1'b0, pc);
        push(0, 9'h0B4, 1'b0, pc);
        push(0, 9'h0C5, 1'b0, pc);
        @(negedge clk);
        dat[0] = 9'h03C;
        repeat (10) @(negedge clk);
        chk(cnt_w[0] == 3'd4, "full_hold_count", int'(cnt_w[0]), 4);
        vld[0] = 1'b0;
        wait_frames(0, f0 + 5, 1500);
        repeat (200) @(posedge clk);
        chk(frames[0] == f0 + 5, "no_dropped_word_frame", frames[0] - f0, 5);
        chk(max_cnt0 <= 4, "max_fifo_count", max_cnt0, 4);

        // 5: reset mid-DATA with three words queued
        f0 = frames[0];
        push(0, 9'h001, 1'b0, pc);
        push(0, 9'h002, 1'b0, pc);
        push(0, 9'h003, 1'b0, pc);
        push(0, 9'h004, 1'b0, pc);
        drop(0);
        repeat (44) @(posedge clk);
        #1;
        chk(cnt_w[0] == 3'd3, "queued_before_reset", int'(cnt_w[0]), 3);
        chk(tx_w[0] !== 1'bx, "line_defined_before_reset", 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk(tx_w[0] == 1'b1, "midframe_reset_tx", int'(tx_w[0]), 1);
        chk(cnt_w[0] == 3'd0, "midframe_reset_count", int'(cnt_w[0]), 0);
        for (int i = expq.size() - 1; i >= 0; i--)
            if (expq[i].idx == 0) expq.delete(i);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        chk(frames[0] == f0, "no_tx_after_reset", frames[0] - f0, 0);
        chk(busy_w[0] == 1'b0, "busy_after_reset", int'(busy_w[0]), 0);
        chk(tx_w[0] == 1'b1, "idle_after_reset", int'(tx_w[0]), 1);

        chk(expq.size() == 0, "scoreboard_empty", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
